// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and state encoding for the fetch sequencer
package fetch_pkg;

  localparam int          INSTR_BYTES      = 4;
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'h8000_0180;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t ST_IDLE    = 2'd0;
  localparam fetch_state_t ST_FETCH   = 2'd1;
  localparam fetch_state_t ST_DELIVER = 2'd2;
  localparam fetch_state_t ST_HALT    = 2'd3;

  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return low_bits != 2'b00;
  endfunction

endpackage

// File: rtl/next_pc_select.sv
// rtl/next_pc_select.sv - next-PC priority mux with word-alignment check
module next_pc_select
  import fetch_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(DEF_EXC_VECTOR)
) (
  input  logic              exception,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic [ADDR_W-1:0] seq_address,
  output logic [ADDR_W-1:0] target,
  output logic              misaligned
);

  always_comb begin
    target = seq_address;
    if (exception) begin
      target = EXC_VECTOR;
    end else if (jump) begin
      target = jump_target;
    end else if (branch_taken) begin
      target = branch_target;
    end
    // only the chosen target matters; a misaligned unused target is harmless
    misaligned = is_misaligned(target[1:0]);
  end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC owner and imem req/ack fetch controller
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(DEF_RESET_VECTOR),
  parameter logic [ADDR_W-1:0] EXC_VECTOR   = ADDR_W'(DEF_EXC_VECTOR),
  parameter int                MAX_WAIT     = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              exception,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [ADDR_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0] instr,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] next_address,
  output logic              fetch_error
);

  localparam int                CNT_W      = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] instr_q, instr_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              flush_q, flush_d;
  logic              fetch_error_q, fetch_error_d;

  logic [ADDR_W-1:0] sel_target;
  logic              sel_misaligned;
  logic              discard;

  assign next_address = pc_q + ADDR_W'(INSTR_BYTES);

  next_pc_select #(
    .ADDR_W     (ADDR_W),
    .EXC_VECTOR (EXC_VECTOR)
  ) u_next_pc_select (
    .exception     (exception),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .seq_address   (next_address),
    .target        (sel_target),
    .misaligned    (sel_misaligned)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    wait_cnt_d    = wait_cnt_q;
    flush_d       = flush_q;
    fetch_error_d = 1'b0;
    // an exception arriving with the ack poisons that word just like a pending flush
    discard       = flush_q | exception;

    case (state_q)
      ST_IDLE: begin
        if (exception) begin
          pc_d = EXC_VECTOR;
        end
        if (run) begin
          state_d = ST_FETCH;
        end
      end

      ST_FETCH: begin
        if (imem_ack) begin
          wait_cnt_d = '0;
          if (discard) begin
            pc_d    = EXC_VECTOR;
            flush_d = 1'b0;
          end else begin
            instr_d = imem_rdata;
            state_d = ST_DELIVER;
          end
        end else if (wait_cnt_q == WAIT_LIMIT) begin
          state_d       = ST_HALT;
          fetch_error_d = 1'b1;
          flush_d       = 1'b0;
          wait_cnt_d    = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
          if (exception) begin
            flush_d = 1'b1;
          end
        end
      end

      ST_DELIVER: begin
        if (!stall) begin
          pc_d          = sel_misaligned ? EXC_VECTOR : sel_target;
          fetch_error_d = sel_misaligned;
          state_d       = run ? ST_FETCH : ST_IDLE;
        end else if (exception) begin
          pc_d    = EXC_VECTOR;
          state_d = run ? ST_FETCH : ST_IDLE;
        end
      end

      default: begin
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_VECTOR;
      instr_q       <= '0;
      wait_cnt_q    <= '0;
      flush_q       <= 1'b0;
      fetch_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      wait_cnt_q    <= wait_cnt_d;
      flush_q       <= flush_d;
      fetch_error_q <= fetch_error_d;
    end
  end

  // request and valid follow the state directly so reset drops them asynchronously
  assign imem_req    = (state_q == ST_FETCH);
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = (state_q == ST_DELIVER);
  assign pc          = pc_q;
  assign fetch_error = fetch_error_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

  localparam logic [31:0] EXC      = 32'h8000_0180;
  localparam int          MAX_WAIT = 15;

  logic        clock         = 1'b0;
  logic        reset         = 1'b0;
  logic        run           = 1'b0;
  logic        stall         = 1'b1;
  logic        branch_taken  = 1'b0;
  logic [31:0] branch_target = '0;
  logic        jump          = 1'b0;
  logic [31:0] jump_target   = '0;
  logic        exception     = 1'b0;
  logic        imem_ack      = 1'b0;
  logic [31:0] imem_rdata    = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] next_address;
  logic        fetch_error;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [31:0] last_word = '0;

  always #5 clock = ~clock;

  fetch_sequencer #(
    .ADDR_W       (32),
    .RESET_VECTOR (32'h0000_0000),
    .EXC_VECTOR   (EXC),
    .MAX_WAIT     (MAX_WAIT)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .run           (run),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .exception     (exception),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .pc            (pc),
    .next_address  (next_address),
    .fetch_error   (fetch_error)
  );

  typedef struct {
    logic [31:0] start_pc;
    logic        exc;
    logic        jmp;
    logic [31:0] jt;
    logic        br;
    logic [31:0] bt;
    logic [31:0] exp_addr;
    logic        exp_err;
  } redir_vec_t;

  redir_vec_t vecs[8];

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  task automatic wait_req(input string name);
    int n;
    n = 0;
    while (!imem_req && n < 40) begin
      cyc();
      n++;
    end
    chk({name, " req_seen"}, 32'(imem_req), 32'd1);
  endtask

  task automatic fetch_ack(input logic [31:0] data, input int delay);
    repeat (delay) cyc();
    imem_ack   = 1'b1;
    imem_rdata = data;
    last_word  = data;
    cyc();
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
  endtask

  task automatic redirect(input logic exc, input logic jmp, input logic [31:0] jt,
                          input logic br, input logic [31:0] bt);
    exception     = exc;
    jump          = jmp;
    jump_target   = jt;
    branch_taken  = br;
    branch_target = bt;
    stall         = 1'b0;
    cyc();
    exception    = 1'b0;
    jump         = 1'b0;
    branch_taken = 1'b0;
    stall        = 1'b1;
  endtask

  task automatic goto_deliver(input logic [31:0] start, input string name);
    logic [31:0] w;
    w = $urandom;
    redirect(1'b0, 1'b1, start, 1'b0, '0);
    fetch_ack(w, 0);
    chk({name, " start_pc"}, pc, start);
    chk({name, " start_instr"}, instr, w);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] expv;
    logic [31:0] w;
    logic [31:0] jt;
    logic [31:0] bt;
    logic        j;
    logic        b;
    int          n;

    vecs[0] = '{32'h0000_0000, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0040, 32'h0000_0040, 1'b0};
    vecs[1] = '{32'h0000_0040, 1'b0, 1'b1, 32'h0000_0100, 1'b1, 32'h0000_0040, 32'h0000_0100, 1'b0};
    vecs[2] = '{32'h0000_0100, 1'b1, 1'b1, 32'h0000_0100, 1'b1, 32'h0000_0040, EXC,           1'b0};
    vecs[3] = '{32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0000_0000, 1'b0};
    vecs[4] = '{32'h0000_0200, 1'b0, 1'b1, 32'h0000_0102, 1'b0, 32'h0,         EXC,           1'b1};
    vecs[5] = '{32'h0000_0200, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0203, EXC,           1'b1};
    vecs[6] = '{32'h0000_0300, 1'b0, 1'b1, 32'h0000_1000, 1'b1, 32'h0000_0041, 32'h0000_1000, 1'b0};
    vecs[7] = '{32'h7FFF_FFF8, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h7FFF_FFFC, 1'b0};

    // reset state
    #12;
    chk("reset imem_req", 32'(imem_req), 32'd0);
    chk("reset instr_valid", 32'(instr_valid), 32'd0);
    chk("reset instr", instr, 32'h0);
    chk("reset pc", pc, 32'h0);
    chk("reset fetch_error", 32'(fetch_error), 32'd0);
    chk("reset next_address", next_address, 32'h4);
    @(negedge clock);
    reset = 1'b1;
    cyc();
    chk("idle no req", 32'(imem_req), 32'd0);

    // first fetch, ack two cycles after request
    run = 1'b1;
    cyc();
    wait_req("t1");
    chk("t1 addr", imem_addr, 32'h0);
    cyc();
    cyc();
    chk("t1 valid before ack", 32'(instr_valid), 32'd0);
    chk("t1 addr held", imem_addr, 32'h0);
    fetch_ack(32'h2008_0005, 0);
    chk("t1 valid after ack", 32'(instr_valid), 32'd1);
    chk("t1 instr", instr, 32'h2008_0005);

    // stall holds the delivered word
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall instr", instr, 32'h2008_0005);
      chk("stall pc", pc, 32'h0);
      chk("stall no req", 32'(imem_req), 32'd0);
      chk("stall valid", 32'(instr_valid), 32'd1);
    end
    redirect(1'b0, 1'b0, '0, 1'b0, '0);
    chk("t1 next seq addr", imem_addr, 32'h4);
    fetch_ack($urandom, 0);

    // redirect priority / misalign / wrap table
    for (int i = 0; i < 8; i++) begin
      goto_deliver(vecs[i].start_pc, $sformatf("vec%0d", i));
      redirect(vecs[i].exc, vecs[i].jmp, vecs[i].jt, vecs[i].br, vecs[i].bt);
      chk($sformatf("vec%0d addr", i), imem_addr, vecs[i].exp_addr);
      chk($sformatf("vec%0d err", i), 32'(fetch_error), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d req", i), 32'(imem_req), 32'd1);
      cyc();
      chk($sformatf("vec%0d err pulse end", i), 32'(fetch_error), 32'd0);
      fetch_ack($urandom, 0);
    end

    // exception during FETCH discards the acked word
    w = last_word;
    redirect(1'b0, 1'b0, '0, 1'b0, '0);
    exception = 1'b1;
    cyc();
    exception  = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    cyc();
    imem_ack = 1'b0;
    chk("flush valid", 32'(instr_valid), 32'd0);
    chk("flush instr kept", instr, w);
    chk("flush req", 32'(imem_req), 32'd1);
    chk("flush addr", imem_addr, EXC);
    fetch_ack(32'h1234_5678, 1);
    chk("flush refetch instr", instr, 32'h1234_5678);

    // exception in DELIVER while stalled
    goto_deliver(32'h0000_0500, "dexc");
    exception = 1'b1;
    cyc();
    exception = 1'b0;
    chk("dexc valid", 32'(instr_valid), 32'd0);
    chk("dexc addr", imem_addr, EXC);
    fetch_ack($urandom, 0);

    // run dropped mid-fetch: word still delivered, then IDLE
    redirect(1'b0, 1'b0, '0, 1'b0, '0);
    run = 1'b0;
    fetch_ack(32'hCAFE_0001, 1);
    chk("stop valid", 32'(instr_valid), 32'd1);
    chk("stop instr", instr, 32'hCAFE_0001);
    redirect(1'b0, 1'b0, '0, 1'b0, '0);
    chk("stop idle req", 32'(imem_req), 32'd0);
    cyc();
    chk("stop idle req2", 32'(imem_req), 32'd0);
    exception = 1'b1;
    cyc();
    exception = 1'b0;
    chk("idle exc pc", pc, EXC);
    run = 1'b1;
    cyc();
    wait_req("idle restart");
    chk("idle restart addr", imem_addr, EXC);

    // timeout: request held MAX_WAIT+1 cycles, then error and HALT
    n = 0;
    while (imem_req && n < 40) begin
      n++;
      cyc();
    end
    chk("timeout req cycles", 32'(n), 32'(MAX_WAIT + 1));
    chk("timeout err", 32'(fetch_error), 32'd1);
    chk("timeout pc frozen", pc, EXC);
    cyc();
    chk("timeout err pulse end", 32'(fetch_error), 32'd0);
    repeat (3) cyc();
    chk("halt req", 32'(imem_req), 32'd0);
    chk("halt valid", 32'(instr_valid), 32'd0);
    chk("halt pc", pc, EXC);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("halt reset pc", pc, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    cyc();
    wait_req("post halt");
    chk("post halt addr", imem_addr, 32'h0);

    // asynchronous reset mid-handshake
    #2;
    reset = 1'b0;
    #1;
    chk("async reset req", 32'(imem_req), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    cyc();

    // randomized transactions against a transaction-level model
    expv = 32'h0;
    for (int t = 0; t < 60; t++) begin
      wait_req($sformatf("rnd%0d", t));
      chk($sformatf("rnd%0d addr", t), imem_addr, expv);
      w = $urandom;
      fetch_ack(w, $urandom_range(0, 4));
      chk($sformatf("rnd%0d valid", t), 32'(instr_valid), 32'd1);
      n = $urandom_range(0, 3);
      for (int s = 0; s < n; s++) begin
        jump          = 1'($urandom);
        jump_target   = $urandom;
        branch_taken  = 1'($urandom);
        branch_target = $urandom;
        cyc();
      end
      chk($sformatf("rnd%0d instr", t), instr, w);
      jt = $urandom;
      jt[1:0] = 2'b00;
      bt = $urandom;
      bt[1:0] = 2'b00;
      j = 1'($urandom_range(0, 3) == 0);
      b = 1'($urandom_range(0, 2) == 0);
      if (j) begin
        expv = jt;
      end else if (b) begin
        expv = bt;
      end else begin
        expv = expv + 32'd4;
      end
      redirect(1'b0, j, jt, b, bt);
      chk($sformatf("rnd%0d err", t), 32'(fetch_error), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
